// File: rtl/fifo_arb_pkg.sv
// Shared defaults and helpers for the arbitrated FIFO front-end.
// Provides the default data width, depth and requester count, the derived
// count width, index-width helpers and the per-cycle FIFO operation encoding.
package fifo_arb_pkg;

  localparam int unsigned FifoDw    = 8;
  localparam int unsigned FifoDepth = 8;
  localparam int unsigned FifoNreq  = 2;
  localparam int unsigned FifoCw    = $clog2(FifoDepth + 1);

  // Width able to hold 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Width of an index into n items; never zero so a single requester still works.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // {write, read} strobes seen by the occupancy counter.
  typedef enum logic [1:0] {
    OpIdle  = 2'b00,
    OpRead  = 2'b01,
    OpWrite = 2'b10,
    OpBoth  = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin write arbiter.
// Ports:
//   clk_i, rst_ni : clock and asynchronous active-low reset
//   en_i          : grants allowed this cycle (low while full or in reset)
//   req_i         : one request bit per requester
//   gnt_o         : one-hot grant, all zero when nothing is granted
// The search starts at rr_ptr; after a grant the pointer moves to the slot
// just past the winner, so the winner has lowest priority next time.
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ = FifoNreq
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] gnt_o
);

  localparam int unsigned IW = idx_width(NREQ);

  logic [IW-1:0]     rr_ptr_d, rr_ptr_q;
  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [IW:0]       sum;
  logic [IW-1:0]     win;
  logic              found;

  always_comb begin
    gnt_o    = '0;
    rr_ptr_d = rr_ptr_q;
    found    = 1'b0;
    sum      = '0;
    win      = '0;
    // Rotate so that bit 0 corresponds to the requester at rr_ptr.
    req_dbl  = {req_i, req_i} >> rr_ptr_q;
    req_rot  = req_dbl[NREQ-1:0];
    if (en_i) begin
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (!found && req_rot[j]) begin
          found = 1'b1;
          sum   = {1'b0, rr_ptr_q} + (IW+1)'(j);
        end
      end
      // Undo the rotation: winner = (rr_ptr + offset) mod NREQ.
      if (sum >= (IW+1)'(NREQ)) begin
        sum = sum - (IW+1)'(NREQ);
      end
      win = sum[IW-1:0];
      if (found) begin
        gnt_o    = NREQ'(1) << win;
        rr_ptr_d = (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/fifo_arbiter.sv
// Arbitrated write front-end and occupancy tracker for an external FIFO (p_fifo).
// Ports:
//   clk, reset            : clock, asynchronous active-low reset (shared with p_fifo)
//   wr_req, wr_data       : NREQ requesters, requester i data at [i*DW +: DW]
//   wr_gnt                : one-hot round-robin grant, zero when full
//   rd_req                : consumer pop request
//   rd_valid, rd_data     : popped data, one cycle after the pop
//   full, empty, count    : occupancy from the registered count
//   fifo_we, fifo_data    : write strobe/data towards p_fifo
//   fifo_rd, fifo_dataout : read strobe towards p_fifo and its registered read data
module fifo_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned DW    = FifoDw,
  parameter int unsigned DEPTH = FifoDepth,
  parameter int unsigned NREQ  = FifoNreq
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NREQ-1:0]               wr_req,
  input  logic [NREQ*DW-1:0]            wr_data,
  output logic [NREQ-1:0]               wr_gnt,
  input  logic                          rd_req,
  output logic                          rd_valid,
  output logic [DW-1:0]                 rd_data,
  output logic                          full,
  output logic                          empty,
  output logic [cnt_width(DEPTH)-1:0]   count,
  output logic                          fifo_we,
  output logic                          fifo_rd,
  output logic [DW-1:0]                 fifo_data,
  input  logic [DW-1:0]                 fifo_dataout
);

  localparam int unsigned CW = cnt_width(DEPTH);

  logic [CW-1:0] count_d, count_q;
  logic          rd_valid_d, rd_valid_q;
  logic          grant_en;
  fifo_op_e      op;

  // Writes are refused whenever full, even if a pop happens in the same cycle.
  // The reset term keeps strobes quiet while reset is held low.
  always_comb begin
    grant_en = reset & ~full;
  end

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr_arbiter (
    .clk_i  (clk),
    .rst_ni (reset),
    .en_i   (grant_en),
    .req_i  (wr_req),
    .gnt_o  (wr_gnt)
  );

  always_comb begin
    fifo_we   = |wr_gnt;
    fifo_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      fifo_data = fifo_data | (wr_data[i*DW +: DW] & {DW{wr_gnt[i]}});
    end
  end

  always_comb begin
    full    = (count_q == CW'(DEPTH));
    empty   = (count_q == '0);
    count   = count_q;
    fifo_rd = rd_req & ~empty & reset;
  end

  always_comb begin
    op         = fifo_op_e'({fifo_we, fifo_rd});
    count_d    = count_q;
    rd_valid_d = fifo_rd;
    unique case (op)
      OpWrite: count_d = count_q + CW'(1);
      OpRead:  count_d = count_q - CW'(1);
      OpIdle,
      OpBoth:  count_d = count_q;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_comb begin
    rd_valid = rd_valid_q;
    rd_data  = fifo_dataout;
  end

endmodule
